cmplx_res_accum: RTL

//  Receiving end of the complex-multiplier result stream (res_val/res_rdy/res_data).
//  - Accepts complex products and sums ACC_LEN of them into one complex dot-product.
//  - Presents the sum on a valid/ready output port.
//  - Sits directly downstream of the complex multiplier.
//  - Applies backpressure on res_rdy while an accumulated result is waiting.

---
 rtl/cmplx_res_accum.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cmplx_res_accum.sv
// rtl/cmplx_res_accum.sv - accumulates ACC_LEN complex products into one complex sum
module cmplx_res_accum #(
    parameter  int DWIDTH  = 8,
    parameter  int ACC_LEN = 4,
    localparam int RW      = 2 * (DWIDTH + 1),
    localparam int AW      = RW + $clog2(ACC_LEN),
    localparam int CW      = $clog2(ACC_LEN + 1)
) (
    input  logic          clk,
    input  logic          sw_rst,
    input  logic          res_val,
    output logic          res_rdy,
    input  logic [2*RW-1:0] res_data,
    input  logic          acc_flush,
    output logic          acc_val,
    input  logic          acc_rdy,
    output logic [2*AW-1:0] acc_data,
    output logic [CW-1:0] acc_cnt
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_re_q, acc_re_d;
    logic [AW-1:0]   acc_im_q, acc_im_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*AW-1:0] acc_data_q, acc_data_d;
    logic [CW-1:0]   acc_cnt_q, acc_cnt_d;
    logic            acc_val_q, acc_val_d;
    logic            res_rdy_q, res_rdy_d;

    logic            res_xfer;
    logic            out_xfer;
    logic [AW-1:0]   sample_re;
    logic [AW-1:0]   sample_im;
    logic [AW-1:0]   sum_re;
    logic [AW-1:0]   sum_im;
    logic [CW-1:0]   cnt_inc;

    assign res_xfer  = res_val & res_rdy_q;
    assign out_xfer  = acc_val_q & acc_rdy;
    assign sample_re = {{(AW-RW){res_data[RW-1]}}, res_data[RW-1:0]};
    assign sample_im = {{(AW-RW){res_data[2*RW-1]}}, res_data[2*RW-1:RW]};
    assign sum_re    = acc_re_q + sample_re;
    assign sum_im    = acc_im_q + sample_im;
    assign cnt_inc   = cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        acc_re_d   = acc_re_q;
        acc_im_d   = acc_im_q;
        cnt_d      = cnt_q;
        acc_data_d = acc_data_q;
        acc_cnt_d  = acc_cnt_q;
        acc_val_d  = acc_val_q;
        res_rdy_d  = res_rdy_q;
        case (state_q)
            ACCUM: begin
                res_rdy_d = 1'b1;
                if (res_xfer) begin
                    if (cnt_inc == CW'(ACC_LEN) || acc_flush) begin
                        acc_data_d = {sum_im, sum_re};
                        acc_cnt_d  = cnt_inc;
                        acc_re_d   = '0;
                        acc_im_d   = '0;
                        cnt_d      = '0;
                        acc_val_d  = 1'b1;
                        res_rdy_d  = 1'b0;
                        state_d    = HOLD;
                    end else begin
                        acc_re_d = sum_re;
                        acc_im_d = sum_im;
                        cnt_d    = cnt_inc;
                    end
                end else if (acc_flush && cnt_q != '0) begin
                    // Flush without a new sample emits the partial sum as-is
                    acc_data_d = {acc_im_q, acc_re_q};
                    acc_cnt_d  = cnt_q;
                    acc_re_d   = '0;
                    acc_im_d   = '0;
                    cnt_d      = '0;
                    acc_val_d  = 1'b1;
                    res_rdy_d  = 1'b0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    acc_val_d = 1'b0;
                    res_rdy_d = 1'b1;
                    state_d   = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            state_q    <= ACCUM;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            cnt_q      <= '0;
            acc_data_q <= '0;
            acc_cnt_q  <= '0;
            acc_val_q  <= 1'b0;
            res_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            cnt_q      <= cnt_d;
            acc_data_q <= acc_data_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_val_q  <= acc_val_d;
            res_rdy_q  <= res_rdy_d;
        end
    end

    assign res_rdy  = res_rdy_q;
    assign acc_val  = acc_val_q;
    assign acc_data = acc_data_q;
    assign acc_cnt  = acc_cnt_q;

endmodule
